dmem_ctrl: RTL and testbench
============================

// Module: dmem_ctrl
// PURPOSE
//  Controller and arbiter in front of the word-wide, synchronous-read data memory (1-cycle read latency).
//  Shares the memory between the CPU load/store port (c_*) and the program/data loader port (l_*).
//  Handles byte/half/word accesses: sign/zero-extends loads; sub-word stores use read-modify-write.
//  Owns every memory control signal; no other block drives the memory.
// PARAMETERS
//  MEM_WORDS  32  data memory depth in 32-bit words; word index = addr[31:2]
//  AW         5   memory word-address width, $clog2(MEM_WORDS)
// PORTS
//  clk        in   1   clock, all state on posedge
//  rst        in   1   synchronous, active-high reset
//  c_req/l_req in  1   request; hold it and all request fields stable until gnt
//  c_we/l_we  in   1   1=store, 0=load
//  c_addr/l_addr in 32 byte address
//  c_size/l_size in 2  00 byte, 01 half, 10 word; 11 illegal
//  c_uns/l_uns in  1   load zero-extend (1) / sign-extend (0)
//  c_wd/l_wd  in   32  store data, lane-aligned at bits [7:0]/[15:0]
//  c_gnt/l_gnt out 1   request accepted this cycle (combinational, IDLE only)
//  c_done/l_done out 1 one-cycle pulse: access complete (registered)
//  c_err/l_err out 1   one-cycle pulse with done: misaligned/illegal/out-of-range
//  c_rd/l_rd  out  32  load result, valid while done=1 (registered)
//  mem_addr   out  AW  word address to memory
//  mem_we     out  1   memory write enable
//  mem_wd     out  32  memory write data
//  mem_rd     in   32  memory read data, valid 1 cycle after mem_addr
// BEHAVIOUR
//  Reset: state=IDLE, gnt/done/err=0, rd=0, mem_we=0, mem_addr=0, mem_wd=0, rr_last=LOADER.
//  FSM states: IDLE, LOAD, RMW_RD, RMW_WR. Grants are issued only in IDLE, so at most one access is in flight.
//  Arbitration in IDLE:
//   - Single requester wins.
//   - Both requesting: round-robin against rr_last; after reset the CPU wins the first tie.
//   - rr_last updates on every grant.
//  Checks at grant (cycle T): misaligned (half with addr[0]=1, word with addr[1:0]!=0), size=11, or word index>=MEM_WORDS
//   -> no memory access, done+err at T+1, state stays IDLE.
//  Word store: mem_we=1 at T with mem_wd=wd; done at T+1; state stays IDLE.
//  Load: mem_addr driven at T; IDLE->LOAD.
//   - In LOAD (T+1): select lane by addr[1:0] and extend per size/uns; register into rd.
//   - done at T+2; LOAD->IDLE.
//  Sub-word store: read at T; IDLE->RMW_RD.
//   - RMW_RD (T+1): merge byte/half lane into mem_rd; IDLE sees nothing.
//   - RMW_RD->RMW_WR: mem_we=1 with merged word at T+2; done at T+3.
//   - RMW_WR->IDLE.
//  Latched request fields (owner, addr, size, uns, wd) are held in regs from T; the requester may change inputs after gnt.
//  Other port:
//   - rd outputs are only updated for the owning port.
//   - Non-owner done/err stays 0.
//   - A request arriving mid-access waits; gnt is never given outside IDLE.
//  Back-to-back: next grant is possible in the cycle done pulses (IDLE again), e.g. at T+1 after a word store.
//  Reset mid-access:
//   - Abandons the access; no done pulse is issued.
//   - A pending RMW write is dropped; mem_we is 0 in the reset cycle.
//  mem_we is 1 only at IDLE word-store grant and in RMW_WR; never two writes to one access.
// STRUCTURE
//  dmem_pkg:
//   - typedef enum {IDLE, LOAD, RMW_RD, RMW_WR} dmem_state_t
//   - size encodings SZ_B/SZ_H/SZ_W
//   - typedef enum {PORT_CPU, PORT_LDR} dmem_port_t
//  Sub-module dmem_lane: combinational lane extract+extend (load) and lane merge (store); used by LOAD and RMW_RD.
// TESTING
//  1 Word store then load: CPU sw 0xDEADBEEF @0x08, lw @0x08 -> done at T+1 and T+2, c_rd=0xDEADBEEF.
//  2 Byte ops: word 0x11223344 @0x0C.
//    - sb 0xAA @0x0D -> word 0x1122AA44, done at T+3.
//    - lb @0x0D -> 0xFFFFFFAA; lbu -> 0x000000AA.
//    - lh @0x0E -> 0x00001122.
//  3 Contention: c_req and l_req high every cycle -> grants alternate CPU,LDR,CPU...; first grant CPU after reset.
//  4 Errors: lw @0x02, sh @0x03, size=11, lw @0x80 (MEM_WORDS=32) -> err+done next cycle, mem_we never 1.
//  5 Reset mid-RMW: assert rst in RMW_RD -> no write to memory, no done, state IDLE; word content unchanged.
//  6 Loader held off: l_req rises while CPU RMW in flight -> l_gnt only once state is IDLE; c_done never coincides with l_done.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory controller.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    RMW_RD = 2'd2,
    RMW_WR = 2'd3
  } dmem_state_t;

  typedef enum logic {
    PORT_CPU = 1'b0,
    PORT_LDR = 1'b1
  } dmem_port_t;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_X = 2'b11;

  // Access is rejected when misaligned, of illegal size, or beyond the memory depth.
  function automatic logic access_bad(input logic [31:0] addr, input logic [1:0] size,
                                      input int unsigned words);
    logic bad;
    bad = (size == SZ_X) ||
          ((size == SZ_H) && addr[0]) ||
          ((size == SZ_W) && (addr[1:0] != 2'b00)) ||
          ({2'b00, addr[31:2]} >= words);
    return bad;
  endfunction

endpackage

// File: rtl/dmem_lane.sv
// Byte/half lane handling: extract+extend for loads, merge into the old word for stores.
module dmem_lane
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [15:0] wd,
  output logic [31:0] load_val,
  output logic [31:0] merged
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b        = word[{offset, 3'b000} +: 8];
    h        = offset[1] ? word[31:16] : word[15:0];
    load_val = word;
    merged   = word;
    case (size)
      SZ_B: begin
        load_val = {{24{b[7] & ~uns}}, b};
        merged[{offset, 3'b000} +: 8] = wd[7:0];
      end
      SZ_H: begin
        load_val = {{16{h[15] & ~uns}}, h};
        if (offset[1]) merged[31:16] = wd;
        else           merged[15:0]  = wd;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Arbiter/controller sharing one synchronous-read data memory between the CPU and loader ports.
// Handshake: a port raises req with stable fields; gnt pulses for one cycle when taken, done(+err) follows.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int MEM_WORDS = 32,
  parameter int AW        = $clog2(MEM_WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [31:0]   c_addr,
  input  logic [1:0]    c_size,
  input  logic          c_uns,
  input  logic [31:0]   c_wd,
  output logic          c_gnt,
  output logic          c_done,
  output logic          c_err,
  output logic [31:0]   c_rd,
  input  logic          l_req,
  input  logic          l_we,
  input  logic [31:0]   l_addr,
  input  logic [1:0]    l_size,
  input  logic          l_uns,
  input  logic [31:0]   l_wd,
  output logic          l_gnt,
  output logic          l_done,
  output logic          l_err,
  output logic [31:0]   l_rd,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [31:0]   mem_wd,
  input  logic [31:0]   mem_rd,
  output logic [1:0]    fsm_state
);

  dmem_state_t state, state_nxt;
  dmem_port_t  rr_last, own;

  logic [AW-1:0] a_idx;
  logic [1:0]    a_off;
  logic [1:0]    a_size;
  logic          a_uns;
  logic [15:0]   a_wd;
  logic [31:0]   merge_q;

  logic          idle_ok, c_win, l_win, any_gnt, bad, word_st;
  logic          r_we, r_uns;
  logic [31:0]   r_addr, r_wd;
  logic [1:0]    r_size;
  logic [31:0]   load_val, merged;

  assign fsm_state = state;

  dmem_lane u_lane (
    .word     (mem_rd),
    .offset   (a_off),
    .size     (a_size),
    .uns      (a_uns),
    .wd       (a_wd),
    .load_val (load_val),
    .merged   (merged)
  );

  // On a tie the port that did not win last time goes first.
  always_comb begin
    idle_ok = (state == IDLE) && !rst;
    c_win   = c_req && (!l_req || (rr_last == PORT_LDR));
    l_win   = l_req && (!c_req || (rr_last == PORT_CPU));
    c_gnt   = idle_ok && c_win;
    l_gnt   = idle_ok && l_win;
    any_gnt = c_gnt || l_gnt;
    r_we    = l_gnt ? l_we   : c_we;
    r_addr  = l_gnt ? l_addr : c_addr;
    r_size  = l_gnt ? l_size : c_size;
    r_uns   = l_gnt ? l_uns  : c_uns;
    r_wd    = l_gnt ? l_wd   : c_wd;
    bad     = access_bad(r_addr, r_size, MEM_WORDS);
    word_st = r_we && (r_size == SZ_W);
  end

  always_comb begin
    state_nxt = state;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wd    = '0;
    case (state)
      IDLE: begin
        if (any_gnt && !bad) begin
          mem_addr = r_addr[AW+1:2];
          if (word_st) begin
            mem_we = 1'b1;
            mem_wd = r_wd;
          end else if (r_we) begin
            state_nxt = RMW_RD;
          end else begin
            state_nxt = LOAD;
          end
        end
      end
      LOAD: begin
        mem_addr  = a_idx;
        state_nxt = IDLE;
      end
      RMW_RD: begin
        mem_addr  = a_idx;
        state_nxt = RMW_WR;
      end
      RMW_WR: begin
        // A reset in this cycle drops the pending write.
        mem_addr  = a_idx;
        mem_we    = !rst;
        mem_wd    = merge_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rr_last <= PORT_LDR;
      own     <= PORT_CPU;
      a_idx   <= '0;
      a_off   <= '0;
      a_size  <= '0;
      a_uns   <= 1'b0;
      a_wd    <= '0;
      merge_q <= '0;
      c_done  <= 1'b0;
      c_err   <= 1'b0;
      c_rd    <= '0;
      l_done  <= 1'b0;
      l_err   <= 1'b0;
      l_rd    <= '0;
    end else begin
      state  <= state_nxt;
      c_done <= 1'b0;
      c_err  <= 1'b0;
      l_done <= 1'b0;
      l_err  <= 1'b0;
      if (any_gnt) begin
        own     <= l_gnt ? PORT_LDR : PORT_CPU;
        rr_last <= l_gnt ? PORT_LDR : PORT_CPU;
        a_idx   <= r_addr[AW+1:2];
        a_off   <= r_addr[1:0];
        a_size  <= r_size;
        a_uns   <= r_uns;
        a_wd    <= r_wd[15:0];
        if (bad || word_st) begin
          c_done <= c_gnt;
          l_done <= l_gnt;
          c_err  <= c_gnt && bad;
          l_err  <= l_gnt && bad;
        end
      end
      case (state)
        LOAD: begin
          if (own == PORT_CPU) begin
            c_rd   <= load_val;
            c_done <= 1'b1;
          end else begin
            l_rd   <= load_val;
            l_done <= 1'b1;
          end
        end
        RMW_RD: merge_q <= merged;
        RMW_WR: begin
          c_done <= (own == PORT_CPU);
          l_done <= (own == PORT_LDR);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: directed steps plus randomized accesses checked against a word-array reference model.
module tb_dmem_ctrl;
  import dmem_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        c_req = 0, c_we = 0, c_uns = 0;
  logic [31:0] c_addr = 0, c_wd = 0;
  logic [1:0]  c_size = 0;
  logic        l_req = 0, l_we = 0, l_uns = 0;
  logic [31:0] l_addr = 0, l_wd = 0;
  logic [1:0]  l_size = 0;
  logic        c_gnt, c_done, c_err, l_gnt, l_done, l_err;
  logic [31:0] c_rd, l_rd;
  logic [4:0]  mem_addr;
  logic        mem_we;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;
  logic [1:0]  fsm_state;

  dmem_ctrl #(.MEM_WORDS(32), .AW(5)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_size(c_size), .c_uns(c_uns), .c_wd(c_wd),
    .c_gnt(c_gnt), .c_done(c_done), .c_err(c_err), .c_rd(c_rd),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_size(l_size), .l_uns(l_uns), .l_wd(l_wd),
    .l_gnt(l_gnt), .l_done(l_done), .l_err(l_err), .l_rd(l_rd),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd),
    .fsm_state(fsm_state)
  );

  // Synchronous-read memory seen by the DUT, with a write counter.
  logic [31:0] mem [32];
  int wr_count = 0;
  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wd;
      wr_count      <= wr_count + 1;
    end
    mem_rd <= mem[mem_addr];
  end

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [32];
  logic [31:0] exp_q [$];
  int checks = 0;
  int errors = 0;

  function automatic bit ref_bad(input logic [31:0] addr, input logic [1:0] size);
    return (size == 2'b11) || (size == 2'b01 && addr[0] == 1'b1) ||
           (size == 2'b10 && addr[1:0] != 2'b00) || ((addr >> 2) >= 32);
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [1:0] size, input bit uns);
    logic [31:0] w, v;
    w = ref_mem[addr[6:2]];
    v = w >> (8 * addr[1:0]);
    if (size == 2'b00) begin
      v = v & 32'hFF;
      if (!uns && v[7]) v = v | 32'hFFFF_FF00;
    end else if (size == 2'b01) begin
      v = v & 32'hFFFF;
      if (!uns && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic void ref_store(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] wd);
    logic [31:0] mask;
    int sh;
    mask = (size == 2'b00) ? 32'hFF : (size == 2'b01) ? 32'hFFFF : 32'hFFFF_FFFF;
    sh   = (size == 2'b10) ? 0 : 8 * addr[1:0];
    ref_mem[addr[6:2]] = (ref_mem[addr[6:2]] & ~(mask << sh)) | ((wd & mask) << sh);
  endfunction

  // ---------------- scoreboard compare ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
      $error("check %s", tag);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input bit port, input bit req, input bit we, input logic [31:0] addr,
                       input logic [1:0] size, input bit uns, input logic [31:0] wd);
    if (port == 1'b0) begin
      c_req = req; c_we = we; c_addr = addr; c_size = size; c_uns = uns; c_wd = wd;
    end else begin
      l_req = req; l_we = we; l_addr = addr; l_size = size; l_uns = uns; l_wd = wd;
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Raise a request, wait for its grant, then scramble the fields to prove they were latched.
  task automatic issue(input bit port, input bit we, input logic [31:0] addr,
                       input logic [1:0] size, input bit uns, input logic [31:0] wd);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    drive(port, 1'b1, we, addr, size, uns, wd);
    for (int i = 0; i < 20; i++) begin
      #1;
      if ((port ? l_gnt : c_gnt) === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("gnt_wait", ok, 1);
    @(posedge clk);
    #1 drive(port, 1'b0, $urandom_range(0, 1), $urandom, 2'($urandom_range(0, 3)), $urandom_range(0, 1), $urandom);
  endtask

  task automatic do_access(input bit port, input bit we, input logic [31:0] addr,
                           input logic [1:0] size, input bit uns, input logic [31:0] wd);
    int lat_exp, lat;
    bit err_exp;
    logic [31:0] rdv;
    bit errv;
    err_exp = ref_bad(addr, size);
    if (err_exp)       lat_exp = 1;
    else if (we) begin
      lat_exp = (size == 2'b10) ? 1 : 3;
      ref_store(addr, size, wd);
    end else begin
      lat_exp = 2;
      exp_q.push_back(ref_load(addr, size, uns));
    end
    issue(port, we, addr, size, uns, wd);
    lat = 0; errv = 1'b0; rdv = '0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check("nonowner_done", port ? c_done : l_done, 0);
      if ((port ? l_done : c_done) === 1'b1) begin
        lat  = k;
        errv = port ? l_err : c_err;
        rdv  = port ? l_rd : c_rd;
        break;
      end
    end
    check("done_latency", lat, lat_exp);
    check("err", errv, err_exp);
    if (!we && !err_exp) check("load_rd", rdv, exp_q.pop_front());
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int wc, ng;
    bit port, we, uns;
    logic [31:0] addr, wd;
    logic [1:0] size;
    int r;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_state", fsm_state, IDLE);
    check("rst_c_gnt", c_gnt, 0);
    check("rst_l_gnt", l_gnt, 0);
    check("rst_c_done", c_done, 0);
    check("rst_l_done", l_done, 0);
    check("rst_c_err", c_err, 0);
    check("rst_l_err", l_err, 0);
    check("rst_c_rd", c_rd, 0);
    check("rst_l_rd", l_rd, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wd", mem_wd, 0);

    for (int i = 0; i < 32; i++) do_access(1, 1, 32'(i * 4), SZ_W, 0, $urandom);

    // word store then load
    do_access(0, 1, 32'h08, SZ_W, 0, 32'hDEAD_BEEF);
    do_access(0, 0, 32'h08, SZ_W, 0, 0);

    // byte/half operations
    do_access(1, 1, 32'h0C, SZ_W, 0, 32'h1122_3344);
    do_access(0, 1, 32'h0D, SZ_B, 0, 32'h0000_00AA);
    do_access(0, 0, 32'h0C, SZ_W, 0, 0);
    do_access(0, 0, 32'h0D, SZ_B, 0, 0);
    do_access(0, 0, 32'h0D, SZ_B, 1, 0);
    do_access(0, 0, 32'h0E, SZ_H, 0, 0);

    // rejected accesses never touch memory
    wc = wr_count;
    do_access(0, 0, 32'h02, SZ_W, 0, 0);
    do_access(0, 1, 32'h03, SZ_H, 0, 32'h1234);
    do_access(1, 0, 32'h10, 2'b11, 0, 0);
    do_access(0, 0, 32'h80, SZ_W, 0, 0);
    do_access(1, 1, 32'h80, SZ_W, 0, 32'h5555_5555);
    check("err_no_write", wr_count, wc);

    // reset during RMW_RD
    wc = wr_count;
    issue(0, 1, 32'h11, SZ_B, 0, 32'h55);
    rst = 1'b1;
    @(negedge clk);
    check("rst_rmwrd_done", c_done, 0);
    check("rst_rmwrd_we", mem_we, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rst_rmwrd_idle", fsm_state, IDLE);
      check("rst_rmwrd_nodone", c_done, 0);
    end
    check("rst_rmwrd_nowrite", wr_count, wc);
    do_access(0, 0, 32'h10, SZ_W, 0, 0);

    // reset during RMW_WR drops the write
    wc = wr_count;
    issue(0, 1, 32'h12, SZ_H, 0, 32'hBEEF);
    @(posedge clk);
    #1 rst = 1'b1;
    #1 check("rst_rmwwr_we", mem_we, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_rmwwr_nodone", c_done, 0);
    check("rst_rmwwr_nowrite", wr_count, wc);
    do_access(1, 0, 32'h10, SZ_W, 0, 0);

    // loader held off while a CPU read-modify-write is in flight
    ref_store(32'h15, SZ_B, 32'h0000_0077);
    issue(0, 1, 32'h15, SZ_B, 0, 32'h77);
    @(negedge clk);
    drive(1, 1, 0, 32'h14, SZ_W, 0, 0);
    #1 check("hold_gnt_k1", l_gnt, 0);
    check("hold_cdone_k1", c_done, 0);
    @(negedge clk);
    #1 check("hold_gnt_k2", l_gnt, 0);
    check("hold_cdone_k2", c_done, 0);
    @(negedge clk);
    #1 check("hold_cdone_k3", c_done, 1);
    check("hold_gnt_k3", l_gnt, 1);
    check("hold_ldone_k3", l_done, 0);
    @(posedge clk);
    #1 drive(1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("hold_ldone_k1", l_done, 0);
    check("hold_cdone_after", c_done, 0);
    @(negedge clk);
    check("hold_ldone_k2", l_done, 1);
    check("hold_l_rd", l_rd, ref_load(32'h14, SZ_W, 0));
    check("hold_cdone_k2b", c_done, 0);

    // contention after reset: CPU first, then strict alternation
    reset_dut();
    @(negedge clk);
    drive(0, 1, 0, 32'h00, SZ_W, 0, 0);
    drive(1, 1, 0, 32'h04, SZ_W, 0, 0);
    ng = 0;
    for (int cyc = 0; cyc < 40 && ng < 6; cyc++) begin
      #1;
      check("cont_overlap", c_done & l_done, 0);
      if (c_done) check("cont_c_rd", c_rd, ref_mem[0]);
      if (l_done) check("cont_l_rd", l_rd, ref_mem[1]);
      if (c_gnt | l_gnt) begin
        check("cont_one_gnt", c_gnt ^ l_gnt, 1);
        check("cont_gnt_port", l_gnt, 32'(ng % 2));
        ng++;
      end
      @(negedge clk);
    end
    check("cont_grants", ng, 6);
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    repeat (4) @(negedge clk);

    // randomized accesses
    for (int n = 0; n < 150; n++) begin
      port = 1'($urandom_range(0, 1));
      we   = 1'($urandom_range(0, 1));
      uns  = 1'($urandom_range(0, 1));
      wd   = $urandom;
      r    = $urandom_range(0, 9);
      size = (r < 3) ? SZ_B : (r < 6) ? SZ_H : (r < 9) ? SZ_W : 2'b11;
      r    = $urandom_range(0, 19);
      if (r == 0)      addr = $urandom;
      else if (r == 1) addr = 32'h80 + $urandom_range(0, 127);
      else             addr = $urandom_range(0, 127);
      if ($urandom_range(0, 3) != 0) begin
        if (size == SZ_H) addr[0] = 1'b0;
        if (size == SZ_W) addr[1:0] = 2'b00;
      end
      do_access(port, we, addr, size, uns, wd);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
